// File: rtl/vektor_laster.sv
// Serial-to-parallel loader: gathers 24 W-bit elements (vectors A..F, four each)
// from a valid/ready stream and presents them as one flat word with valid/ready.

module vektor_laster_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module vektor_laster #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            clear,
  output logic [24*W-1:0] vec_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      count,
  output logic [7:0]      batch_cnt
);
  localparam int NUM_SLOTS = 24;

  typedef enum logic {FILL, FULL} state_t;

  state_t state, state_next;
  logic [4:0] count_next;
  logic       in_hs, out_hs;
  logic [NUM_SLOTS-1:0]        we;
  logic [NUM_SLOTS-1:0][W-1:0] elems;

  // Handshake strobes only from registered state; clear masks both.
  assign in_ready  = (state == FILL);
  assign out_valid = (state == FULL);
  assign in_hs     = in_valid & in_ready & ~clear;
  assign out_hs    = out_valid & out_ready & ~clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      count     <= '0;
      batch_cnt <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (out_hs) batch_cnt <= batch_cnt + 8'd1;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    if (clear) begin
      state_next = FILL;
      count_next = '0;
    end else begin
      unique case (state)
        FILL: if (in_hs) begin
          count_next = count + 5'd1;
          if (count == 5'(NUM_SLOTS - 1)) state_next = FULL;
        end
        FULL: if (out_hs) begin
          count_next = '0;
          state_next = FILL;
        end
        default: state_next = FILL;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    assign we[k] = in_hs && (count == 5'(k));
    vektor_laster_slot #(.W(W)) u_slot (
      .clk (clk),
      .rst (rst),
      .we  (we[k]),
      .d   (in_data),
      .q   (elems[k])
    );
  end

  // Slot k lands at bits [k*W +: W].
  assign vec_out = elems;
endmodule

// File: tb/tb_vektor_laster.sv
// Directed bench for vektor_laster: vector tables for clear corner cases plus
// hand-written load/unload sequences with a bench-side element model.

module tb_vektor_laster;
  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            clear = 1'b0;
  logic [24*W-1:0] vec_out;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [4:0]      count;
  logic [7:0]      batch_cnt;

  vektor_laster #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
    .vec_out   (vec_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .batch_cnt (batch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       clr;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [4:0] e_cnt;
    logic [7:0] e_bc;
  } vec_t;

  vec_t tv [0:5];
  logic [23:0][7:0] mdl;
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_vec(input string name);
    n_tot++;
    if (vec_out === mdl) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, vec_out, mdl);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic ir, input logic ov,
                           input logic [4:0] c, input logic [7:0] bc);
    chk({name, ".in_ready"},  32'(in_ready),  32'(ir));
    chk({name, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({name, ".count"},     32'(count),     32'(c));
    chk({name, ".batch_cnt"}, 32'(batch_cnt), 32'(bc));
  endtask

  // Push n elements into slots start..start+n-1; optional random idle gaps.
  task automatic load(input int n, input int start, input logic [7:0] base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 1);
        for (int j = 0; j < g; j++) begin
          in_valid = 1'b0;
          step();
        end
      end
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      chk("load.in_ready", 32'(in_ready), 32'd1);
      step();
      mdl[start + i] = base + 8'(i);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mdl = '0;
  endtask

  task automatic apply(input int idx, input string name);
    in_valid  = tv[idx].iv;
    in_data   = tv[idx].d;
    clear     = tv[idx].clr;
    out_ready = tv[idx].ordy;
    step();
    chk_state(name, tv[idx].e_ir, tv[idx].e_ov, tv[idx].e_cnt, tv[idx].e_bc);
    clear = 1'b0;
  endtask

  initial begin
    // {iv, d, clr, ordy} -> {in_ready, out_valid, count, batch_cnt}
    tv[0] = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'd3};
    tv[1] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 8'd3};
    tv[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 8'd3};
    tv[3] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 8'd3};
    tv[4] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 8'd3};
    tv[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'd3};

    mdl = '0;
    #2;
    chk_state("reset", 1'b1, 1'b0, 5'd0, 8'd0);
    chk_vec("reset.vec");
    step();
    rst = 1'b0;

    // Back-to-back batch 0x01..0x18, downstream stalled.
    load(24, 0, 8'h01, 1'b0);
    chk_state("full", 1'b0, 1'b1, 5'd24, 8'd0);
    chk("full.a1", 32'(vec_out[7:0]),     32'h01);
    chk("full.b1", 32'(vec_out[39:32]),   32'h05);
    chk("full.f4", 32'(vec_out[191:184]), 32'h18);
    chk_vec("full.vec");

    // Source keeps pushing 0xFF while held off.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold.in_ready", 32'(in_ready), 32'd0);
      chk_vec("hold.vec");
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk_state("drain", 1'b1, 1'b0, 5'd0, 8'd1);

    // Three batches with random input gaps, downstream always ready.
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      load(24, 0, 8'(8'h30 + b * 24), 1'b1);
      chk("gap.out_valid", 32'(out_valid), 32'd1);
      chk_vec("gap.vec");
      step();
      chk_state("gap.after", 1'b1, 1'b0, 5'd0, 8'(b + 1));
    end
    out_ready = 1'b0;

    // Clear mid-batch with a simultaneous input handshake, then refill.
    load(10, 0, 8'h40, 1'b0);
    for (int i = 0; i <= 3; i++) apply(i, "clr_fill");
    chk("clr.slot10", 32'(vec_out[87:80]), 32'(mdl[10]));
    mdl[0] = 8'h11;
    mdl[1] = 8'h22;
    out_ready = 1'b0;
    load(22, 2, 8'h60, 1'b0);
    chk_state("refill", 1'b0, 1'b1, 5'd24, 8'd3);
    chk_vec("refill.vec");

    // Clear wins over output handshake in FULL.
    for (int i = 4; i <= 5; i++) apply(i, "clr_full");
    chk_vec("clr_full.vec");
    out_ready = 1'b0;
    in_valid  = 1'b0;

    // Async reset mid-batch.
    load(12, 0, 8'h80, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 1'b1, 1'b0, 5'd0, 8'd0);
    mdl = '0;
    chk_vec("async_rst.vec");
    step();
    rst = 1'b0;

    // 256 batches: batch_cnt wraps.
    out_ready = 1'b1;
    for (int b = 0; b < 256; b++) begin
      load(24, 0, 8'(b), 1'b0);
      step();
      if (b == 254) chk("wrap.255", 32'(batch_cnt), 32'd255);
    end
    chk("wrap.0", 32'(batch_cnt), 32'd0);
    chk("wrap.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
